paddle_locator: RTL and testbench

Frame-level consumer of the thresholded edge stream produced by the convolution stage. It accepts the same valid-qualified RGB pixel bus and tracks raster position with counters. It accumulates a bounding box and a pixel count of edge pixels inside a row region of interest. Once per frame it publishes the paddle box to the game logic.

---
 rtl/paddle_locator.sv | 226 ++++++++++++++++++++++
 tb/tb_paddle_locator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/paddle_locator.sv
// paddle_locator: tracks raster position of an edge-map pixel stream and
// publishes a per-frame bounding box and edge count of the paddle.
module paddle_locator #(
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIXEL_DEPTH  = 8,
    parameter int ROI_Y_MIN    = 0,
    parameter int ROI_Y_MAX    = 479,
    parameter int MIN_PIXELS   = 16,
    localparam int X_W   = $clog2(LINE_WIDTH),
    localparam int Y_W   = $clog2(FRAME_HEIGHT),
    localparam int CNT_W = $clog2(LINE_WIDTH*FRAME_HEIGHT+1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic                   sof_i,
    input  logic [PIXEL_DEPTH-1:0] input_R,
    input  logic [PIXEL_DEPTH-1:0] input_G,
    input  logic [PIXEL_DEPTH-1:0] input_B,
    output logic                   result_valid,
    output logic                   found,
    output logic [X_W-1:0]         x_min,
    output logic [X_W-1:0]         x_max,
    output logic [Y_W-1:0]         y_min,
    output logic [Y_W-1:0]         y_max,
    output logic [CNT_W-1:0]       edge_count,
    output logic                   frame_err
);

    localparam logic [X_W-1:0]   X_LAST  = X_W'(LINE_WIDTH-1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(FRAME_HEIGHT-1);
    localparam logic [Y_W-1:0]   ROI_LO  = Y_W'(ROI_Y_MIN);
    localparam logic [Y_W-1:0]   ROI_HI  = Y_W'(ROI_Y_MAX);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        PUBLISH
    } state_t;

    state_t state_q, state_d;

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [X_W-1:0]   wx_min_q, wx_min_d, wx_max_q, wx_max_d;
    logic [Y_W-1:0]   wy_min_q, wy_min_d, wy_max_q, wy_max_d;
    logic [CNT_W-1:0] wcount_q, wcount_d;
    logic             whit_q, whit_d;

    logic             restart;
    logic             edge_px;
    logic             proc;
    logic             pub_load;
    logic             err_set;
    logic             is_last;
    logic             in_roi;
    logic             roi_lo_ok;
    logic             roi_hi_ok;
    logic             hit_px;
    logic             found_d;
    logic [X_W-1:0]   px;
    logic [Y_W-1:0]   py;

    // A pixel carrying sof is always placed at (0,0) on top of cleared state.
    assign restart = valid_i & sof_i;
    assign edge_px = input_R[PIXEL_DEPTH-1]
                   | input_G[PIXEL_DEPTH-1]
                   | input_B[PIXEL_DEPTH-1];
    assign px      = restart ? '0 : x_q;
    assign py      = restart ? '0 : y_q;
    assign is_last = (px == X_LAST) && (py == Y_LAST);

    if (ROI_Y_MIN == 0) begin : g_roi_lo
        assign roi_lo_ok = 1'b1;
    end else begin : g_roi_lo
        assign roi_lo_ok = (py >= ROI_LO);
    end

    if (ROI_Y_MAX >= (1 << Y_W) - 1) begin : g_roi_hi
        assign roi_hi_ok = 1'b1;
    end else begin : g_roi_hi
        assign roi_hi_ok = (py <= ROI_HI);
    end

    assign in_roi = roi_lo_ok & roi_hi_ok;
    assign hit_px = proc & edge_px & in_roi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (restart) state_d = ACCUM;
            end
            ACCUM: begin
                if (valid_i && !sof_i && is_last) state_d = PUBLISH;
            end
            PUBLISH: begin
                state_d = restart ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        proc     = 1'b0;
        pub_load = 1'b0;
        err_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                proc = restart;
            end
            ACCUM: begin
                proc     = valid_i;
                pub_load = valid_i & ~sof_i & is_last;
                err_set  = restart;
            end
            PUBLISH: begin
                proc = restart;
            end
            default: ;
        endcase
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        wx_min_d = wx_min_q;
        wx_max_d = wx_max_q;
        wy_min_d = wy_min_q;
        wy_max_d = wy_max_q;
        wcount_d = wcount_q;
        whit_d   = whit_q;
        if (proc) begin
            if (restart) begin
                wx_min_d = '0;
                wx_max_d = '0;
                wy_min_d = '0;
                wy_max_d = '0;
                wcount_d = '0;
                whit_d   = 1'b0;
            end
            if (hit_px) begin
                if (!whit_d) begin
                    wx_min_d = px;
                    wx_max_d = px;
                    wy_min_d = py;
                    wy_max_d = py;
                end else begin
                    if (px < wx_min_d) wx_min_d = px;
                    if (px > wx_max_d) wx_max_d = px;
                    if (py < wy_min_d) wy_min_d = py;
                    if (py > wy_max_d) wy_max_d = py;
                end
                whit_d = 1'b1;
                if (wcount_d != '1) wcount_d = wcount_d + CNT_W'(1);
            end
            if (px == X_LAST) begin
                x_d = '0;
                y_d = (py == Y_LAST) ? '0 : py + 1'b1;
            end else begin
                x_d = px + 1'b1;
                y_d = py;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            wx_min_q <= '0;
            wx_max_q <= '0;
            wy_min_q <= '0;
            wy_max_q <= '0;
            wcount_q <= '0;
            whit_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            wx_min_q <= wx_min_d;
            wx_max_q <= wx_max_d;
            wy_min_q <= wy_min_d;
            wy_max_q <= wy_max_d;
            wcount_q <= wcount_d;
            whit_q   <= whit_d;
        end
    end

    // Results load on the edge that accepts the last pixel, so they include it.
    assign found_d = whit_d & (wcount_d >= MIN_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
            found        <= 1'b0;
            x_min        <= '0;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
            edge_count   <= '0;
        end else begin
            result_valid <= pub_load;
            frame_err    <= err_set;
            if (pub_load) begin
                found      <= found_d;
                x_min      <= found_d ? wx_min_d : '0;
                x_max      <= found_d ? wx_max_d : '0;
                y_min      <= found_d ? wy_min_d : '0;
                y_max      <= found_d ? wy_max_d : '0;
                edge_count <= wcount_d;
            end
        end
    end

endmodule

// File: tb/tb_paddle_locator.sv
// tb_paddle_locator: directed frames on an 8x4 raster with ROI lines 1..3,
// covering gaps, early sof, back-to-back frames and mid-frame reset.
module tb_paddle_locator;

    localparam int LW = 8;
    localparam int FH = 4;
    localparam int PD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_i;
    logic          sof_i;
    logic [PD-1:0] input_R;
    logic [PD-1:0] input_G;
    logic [PD-1:0] input_B;
    logic          result_valid;
    logic          found;
    logic [2:0]    x_min;
    logic [2:0]    x_max;
    logic [1:0]    y_min;
    logic [1:0]    y_max;
    logic [5:0]    edge_count;
    logic          frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    paddle_locator #(
        .LINE_WIDTH  (LW),
        .FRAME_HEIGHT(FH),
        .PIXEL_DEPTH (PD),
        .ROI_Y_MIN   (1),
        .ROI_Y_MAX   (3),
        .MIN_PIXELS  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (valid_i),
        .sof_i       (sof_i),
        .input_R     (input_R),
        .input_G     (input_G),
        .input_B     (input_B),
        .result_valid(result_valid),
        .found       (found),
        .x_min       (x_min),
        .x_max       (x_max),
        .y_min       (y_min),
        .y_max       (y_max),
        .edge_count  (edge_count),
        .frame_err   (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] f,
                           input logic [31:0] xl, input logic [31:0] xh,
                           input logic [31:0] yl, input logic [31:0] yh,
                           input logic [31:0] c);
        chk({tag, ".found"}, 32'(found), f);
        chk({tag, ".x_min"}, 32'(x_min), xl);
        chk({tag, ".x_max"}, 32'(x_max), xh);
        chk({tag, ".y_min"}, 32'(y_min), yl);
        chk({tag, ".y_max"}, 32'(y_max), yh);
        chk({tag, ".count"}, 32'(edge_count), c);
    endtask

    // Drive one accepted pixel, then wait to the following negedge.
    task automatic drive_px(input bit s, input bit e, input int idx);
        valid_i = 1'b1;
        sof_i   = s;
        input_R = 8'h7F;
        input_G = 8'h7F;
        input_B = 8'h7F;
        if (e) begin
            case (idx % 3)
                0:       input_R = 8'h80;
                1:       input_G = 8'hC0;
                default: input_B = 8'hFF;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic gap();
        valid_i = 1'b0;
        sof_i   = 1'($urandom_range(0, 1));
        input_R = 8'hFF;
        input_G = 8'hFF;
        input_B = 8'hFF;
        @(negedge clk);
    endtask

    task automatic idle();
        valid_i = 1'b0;
        sof_i   = 1'b0;
        input_R = 8'h00;
        input_G = 8'h00;
        input_B = 8'h00;
        @(negedge clk);
    endtask

    task automatic frame(input string tag, input logic [31:0] mask,
                         input bit gaps, input bit err0,
                         input logic [31:0] f, input logic [31:0] xl,
                         input logic [31:0] xh, input logic [31:0] yl,
                         input logic [31:0] yh, input logic [31:0] c);
        bit spur;
        spur = 1'b0;
        for (int i = 0; i < LW * FH; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    gap();
                    spur |= result_valid | frame_err;
                end
            end
            drive_px(i == 0, mask[i], i);
            if (i == 0) chk({tag, ".err0"}, 32'(frame_err), 32'(err0));
            else if (i < LW * FH - 1) spur |= frame_err;
            if (i < LW * FH - 1) spur |= result_valid;
        end
        chk({tag, ".spurious"}, 32'(spur), 0);
        chk({tag, ".rv"}, 32'(result_valid), 1);
        chk_out(tag, f, xl, xh, yl, yh, c);
    endtask

    localparam logic [31:0] M1 = 32'h0820_0400;
    localparam logic [31:0] M2 = 32'h0010_0002;
    localparam logic [31:0] MB = 32'h8000_0100;
    localparam logic [31:0] MP = 32'h0000_0300;

    initial begin
        bit spur;
        reset   = 1'b1;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        input_R = '0;
        input_G = '0;
        input_B = '0;
        repeat (3) @(negedge clk);
        chk("rst.rv", 32'(result_valid), 0);
        chk("rst.err", 32'(frame_err), 0);
        chk_out("rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        idle();

        frame("s1", M1, 1'b0, 1'b0, 1, 2, 5, 1, 3, 3);
        idle();
        chk("s1.rv_pulse", 32'(result_valid), 0);
        chk("s1.hold", 32'(found), 1);

        frame("s2", M2, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
        idle();

        frame("s3", M1, 1'b1, 1'b0, 1, 2, 5, 1, 3, 3);
        idle();

        for (int i = 0; i < 10; i++) drive_px(i == 0, MP[i], i);
        chk("s4.no_err_yet", 32'(frame_err), 0);
        frame("s4", M1, 1'b0, 1'b1, 1, 2, 5, 1, 3, 3);
        idle();

        frame("s5a", M1, 1'b0, 1'b0, 1, 2, 5, 1, 3, 3);
        frame("s5b", MB, 1'b0, 1'b0, 1, 0, 7, 1, 3, 2);
        idle();

        for (int i = 0; i < 20; i++) drive_px(i == 0, M1[i], i);
        reset = 1'b1;
        drive_px(1'b0, 1'b1, 20);
        chk("s6.rv", 32'(result_valid), 0);
        chk("s6.err", 32'(frame_err), 0);
        chk_out("s6", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        spur  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive_px(1'b0, 1'b1, i);
            spur |= result_valid | frame_err;
        end
        chk("s6.ignored", 32'(spur), 0);
        chk("s6.count", 32'(edge_count), 0);
        frame("s6r", M1, 1'b0, 1'b0, 1, 2, 5, 1, 3, 3);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
